// File: rtl/fetch_ctrl.sv
// Fetch controller: boot loader sequencing, PC stall/redirect arbitration and pending redirects.
// Optional performance counters are built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_req,
    input  logic [15:0] boot_len,
    input  logic        boot_valid,
    output logic        boot_ready,
    output logic        bmem_we,
    output logic [31:0] bmem_addr,
    input  logic        imem_busy,
    input  logic        hazard_stall,
    input  logic        halt,
    input  logic        trap,
    input  logic [31:0] trap_vec,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_addr,
    input  logic        id_jmp,
    input  logic [31:0] id_jmp_addr,
    output logic        pc_stall,
    output logic        pc_flow_change,
    output logic [31:0] pc_br_addr,
    output logic        pc_boot_en,
    output logic        flush_if,
    output logic        flush_id,
    output logic        if_valid,
    output logic [1:0]  state,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redir_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BOOT = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_e;

    localparam logic [1:0] RANK_NONE = 2'd0;
    localparam logic [1:0] RANK_JMP  = 2'd1;
    localparam logic [1:0] RANK_BR   = 2'd2;
    localparam logic [1:0] RANK_TRAP = 2'd3;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_rank_q, pend_rank_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic [1:0]  new_rank;
    logic [31:0] new_addr;
    logic        new_valid;
    logic        new_wins;
    logic        issue_slot;
    logic        issue_new;
    logic        issue_pend;
    logic        latch_ok;

    always_comb begin
        new_rank = RANK_NONE;
        new_addr = '0;
        if (trap) begin
            new_rank = RANK_TRAP;
            new_addr = trap_vec;
        end else if (ex_br_taken) begin
            new_rank = RANK_BR;
            new_addr = ex_br_addr;
        end else if (id_jmp) begin
            new_rank = RANK_JMP;
            new_addr = id_jmp_addr;
        end
    end

    // A new redirect beats a pending one only at higher or equal rank.
    assign new_valid  = (new_rank != RANK_NONE);
    assign new_wins   = new_valid && (!pend_valid_q || (new_rank >= pend_rank_q));
    assign issue_slot = (state_q == S_RUN) && !imem_busy;
    assign latch_ok   = (state_q == S_RUN) || (state_q == S_HALT);
    assign issue_new  = issue_slot && new_wins;
    assign issue_pend = issue_slot && pend_valid_q && !new_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_rank_q  <= RANK_NONE;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            pend_valid_q <= pend_valid_d;
            pend_rank_q  <= pend_rank_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        pend_valid_d = pend_valid_q;
        pend_rank_d  = pend_rank_q;
        pend_addr_d  = pend_addr_q;

        case (state_q)
            S_IDLE: begin
                if (boot_req) begin
                    cnt_d   = '0;
                    addr_d  = '0;
                    len_d   = boot_len;
                    state_d = (boot_len == 16'd0) ? S_RUN : S_BOOT;
                end
            end
            S_BOOT: begin
                if (boot_valid) begin
                    cnt_d  = cnt_q + 16'd1;
                    addr_d = addr_q + 32'd4;
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (!halt) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any issue slot consumes the pending entry; a losing new redirect is dropped.
        if (issue_slot) begin
            pend_valid_d = 1'b0;
        end else if (latch_ok && new_wins) begin
            pend_valid_d = 1'b1;
            pend_rank_d  = new_rank;
            pend_addr_d  = new_addr;
        end
    end

    always_comb begin
        boot_ready     = 1'b0;
        bmem_we        = 1'b0;
        pc_boot_en     = 1'b1;
        pc_stall       = 1'b1;
        pc_flow_change = 1'b0;
        pc_br_addr     = '0;
        flush_if       = 1'b0;
        flush_id       = 1'b0;
        if_valid       = 1'b0;
        if (!rst) begin
            boot_ready     = (state_q == S_BOOT);
            bmem_we        = (state_q == S_BOOT) && boot_valid;
            pc_boot_en     = (state_q == S_IDLE) || (state_q == S_BOOT);
            pc_flow_change = issue_new || issue_pend;
            if (issue_new) begin
                pc_br_addr = new_addr;
            end else if (issue_pend) begin
                pc_br_addr = pend_addr_q;
            end
            pc_stall = !(issue_new || issue_pend) &&
                       (imem_busy || hazard_stall || (state_q != S_RUN));
            flush_if = new_valid;
            flush_id = trap || ex_br_taken;
            if_valid = (state_q == S_RUN) && !imem_busy && !new_valid && !pend_valid_q;
        end
    end

    assign bmem_addr = addr_q;
    assign state     = state_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redir_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if ((state_q == S_RUN) && pc_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pc_flow_change) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_redir_cnt = redir_cnt_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, corner-case sequences and random traffic
// checked against a behavioural model of the fetch/boot rules.
module tb_fetch_ctrl;

    typedef struct {
        logic        rst;
        logic        boot_req;
        logic [15:0] boot_len;
        logic        boot_valid;
        logic        imem_busy;
        logic        hazard_stall;
        logic        halt;
        logic        trap;
        logic [31:0] trap_vec;
        logic        ex_br_taken;
        logic [31:0] ex_br_addr;
        logic        id_jmp;
        logic [31:0] id_jmp_addr;
    } in_t;

    typedef struct {
        logic        boot_ready;
        logic        bmem_we;
        logic [31:0] bmem_addr;
        logic        pc_stall;
        logic        pc_flow_change;
        logic [31:0] pc_br_addr;
        logic        pc_boot_en;
        logic        flush_if;
        logic        flush_id;
        logic        if_valid;
        logic [1:0]  state;
        logic [31:0] perf_stall_cnt;
        logic [31:0] perf_redir_cnt;
    } out_t;

    typedef struct {
        in_t         in;
        logic        stall;
        logic        flow;
        logic [31:0] addr;
        logic        fi;
        logic        fd;
        logic        iv;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        boot_req;
    logic [15:0] boot_len;
    logic        boot_valid;
    logic        boot_ready;
    logic        bmem_we;
    logic [31:0] bmem_addr;
    logic        imem_busy;
    logic        hazard_stall;
    logic        halt;
    logic        trap;
    logic [31:0] trap_vec;
    logic        ex_br_taken;
    logic [31:0] ex_br_addr;
    logic        id_jmp;
    logic [31:0] id_jmp_addr;
    logic        pc_stall;
    logic        pc_flow_change;
    logic [31:0] pc_br_addr;
    logic        pc_boot_en;
    logic        flush_if;
    logic        flush_id;
    logic        if_valid;
    logic [1:0]  state;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redir_cnt;

    int vec_cnt;
    int miss_cnt;

    // Behavioural model state: mode 0..3, words accepted, pending redirect.
    int          m_state;
    int          m_loaded;
    int          m_len;
    bit          m_pv;
    int          m_prank;
    logic [31:0] m_paddr;
    logic [31:0] m_pstall;
    logic [31:0] m_predir;

    in_t  cur_v;
    out_t cur_e;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .boot_req       (boot_req),
        .boot_len       (boot_len),
        .boot_valid     (boot_valid),
        .boot_ready     (boot_ready),
        .bmem_we        (bmem_we),
        .bmem_addr      (bmem_addr),
        .imem_busy      (imem_busy),
        .hazard_stall   (hazard_stall),
        .halt           (halt),
        .trap           (trap),
        .trap_vec       (trap_vec),
        .ex_br_taken    (ex_br_taken),
        .ex_br_addr     (ex_br_addr),
        .id_jmp         (id_jmp),
        .id_jmp_addr    (id_jmp_addr),
        .pc_stall       (pc_stall),
        .pc_flow_change (pc_flow_change),
        .pc_br_addr     (pc_br_addr),
        .pc_boot_en     (pc_boot_en),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .if_valid       (if_valid),
        .state          (state),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_redir_cnt (perf_redir_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic int rank_of(input in_t v);
        if (v.trap) return 3;
        if (v.ex_br_taken) return 2;
        if (v.id_jmp) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] target_of(input in_t v);
        if (v.trap) return v.trap_vec;
        if (v.ex_br_taken) return v.ex_br_addr;
        if (v.id_jmp) return v.id_jmp_addr;
        return 32'd0;
    endfunction

    function automatic out_t model_out(input in_t v);
        out_t e;
        int   nr;
        e = '{default: '0};
        e.bmem_addr      = 32'(m_loaded * 4);
        e.state          = 2'(m_state);
        e.perf_stall_cnt = m_pstall;
        e.perf_redir_cnt = m_predir;
        if (v.rst) begin
            e.pc_boot_en = 1'b1;
            e.pc_stall   = 1'b1;
            return e;
        end
        nr = rank_of(v);
        e.flush_if   = (nr != 0);
        e.flush_id   = (nr >= 2);
        e.boot_ready = (m_state == 1);
        e.bmem_we    = (m_state == 1) && v.boot_valid;
        e.pc_boot_en = (m_state < 2);
        if (m_state == 2 && !v.imem_busy) begin
            if (nr != 0 && (!m_pv || nr >= m_prank)) begin
                e.pc_flow_change = 1'b1;
                e.pc_br_addr     = target_of(v);
            end else if (m_pv) begin
                e.pc_flow_change = 1'b1;
                e.pc_br_addr     = m_paddr;
            end
        end
        e.pc_stall = !e.pc_flow_change && (v.imem_busy || v.hazard_stall || m_state != 2);
        e.if_valid = (m_state == 2) && !v.imem_busy && (nr == 0) && !m_pv;
        return e;
    endfunction

    task automatic model_step(input in_t v, input out_t e);
        int nr;
        if (v.rst) begin
            m_state  = 0;
            m_loaded = 0;
            m_len    = 0;
            m_pv     = 0;
            m_prank  = 0;
            m_paddr  = '0;
            m_pstall = '0;
            m_predir = '0;
            return;
        end
`ifdef FETCH_CTRL_PERF_EN
        if (m_state == 2 && e.pc_stall) m_pstall = m_pstall + 1;
        if (e.pc_flow_change) m_predir = m_predir + 1;
`endif
        nr = rank_of(v);
        if (m_state == 2 && !v.imem_busy) begin
            m_pv = 0;
        end else if (m_state >= 2 && nr != 0 && (!m_pv || nr >= m_prank)) begin
            m_pv    = 1;
            m_prank = nr;
            m_paddr = target_of(v);
        end
        case (m_state)
            0: if (v.boot_req) begin
                m_loaded = 0;
                m_len    = int'(v.boot_len);
                m_state  = (v.boot_len == 16'd0) ? 2 : 1;
            end
            1: if (v.boot_valid) begin
                m_loaded = m_loaded + 1;
                if (m_loaded == m_len) m_state = 2;
            end
            2: if (v.halt) m_state = 3;
            default: if (!v.halt) m_state = 2;
        endcase
    endtask

    // Drive one cycle of inputs and compare all outputs with the model at the falling edge.
    task automatic apply(input in_t v);
        cur_v        = v;
        rst          = v.rst;
        boot_req     = v.boot_req;
        boot_len     = v.boot_len;
        boot_valid   = v.boot_valid;
        imem_busy    = v.imem_busy;
        hazard_stall = v.hazard_stall;
        halt         = v.halt;
        trap         = v.trap;
        trap_vec     = v.trap_vec;
        ex_br_taken  = v.ex_br_taken;
        ex_br_addr   = v.ex_br_addr;
        id_jmp       = v.id_jmp;
        id_jmp_addr  = v.id_jmp_addr;
        @(negedge clk);
        cur_e = model_out(v);
        chk("m.boot_ready", 32'(boot_ready), 32'(cur_e.boot_ready));
        chk("m.bmem_we", 32'(bmem_we), 32'(cur_e.bmem_we));
        chk("m.bmem_addr", bmem_addr, cur_e.bmem_addr);
        chk("m.pc_stall", 32'(pc_stall), 32'(cur_e.pc_stall));
        chk("m.pc_flow_change", 32'(pc_flow_change), 32'(cur_e.pc_flow_change));
        if (cur_e.pc_flow_change || v.rst) chk("m.pc_br_addr", pc_br_addr, cur_e.pc_br_addr);
        chk("m.pc_boot_en", 32'(pc_boot_en), 32'(cur_e.pc_boot_en));
        chk("m.flush_if", 32'(flush_if), 32'(cur_e.flush_if));
        chk("m.flush_id", 32'(flush_id), 32'(cur_e.flush_id));
        chk("m.if_valid", 32'(if_valid), 32'(cur_e.if_valid));
        chk("m.state", 32'(state), 32'(cur_e.state));
        chk("m.perf_stall_cnt", perf_stall_cnt, cur_e.perf_stall_cnt);
        chk("m.perf_redir_cnt", perf_redir_cnt, cur_e.perf_redir_cnt);
    endtask

    task automatic next();
        model_step(cur_v, cur_e);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic t, input logic [31:0] tv, input logic x,
                                input logic [31:0] xa, input logic j, input logic [31:0] ja,
                                input logic busy, input logic haz, input logic stall,
                                input logic flow, input logic [31:0] addr, input logic fi,
                                input logic fd, input logic iv);
        vec_t r;
        r.in              = idle();
        r.in.trap         = t;
        r.in.trap_vec     = tv;
        r.in.ex_br_taken  = x;
        r.in.ex_br_addr   = xa;
        r.in.id_jmp       = j;
        r.in.id_jmp_addr  = ja;
        r.in.imem_busy    = busy;
        r.in.hazard_stall = haz;
        r.stall = stall;
        r.flow  = flow;
        r.addr  = addr;
        r.fi    = fi;
        r.fd    = fd;
        r.iv    = iv;
        return r;
    endfunction

    vec_t tbl[10];

    initial begin
        in_t v;
        vec_cnt  = 0;
        miss_cnt = 0;

        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0, 0, 1);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 0, 0, 0);
        tbl[3] = mk(1, 32'h100, 1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 32'h100, 1, 1, 0);
        tbl[4] = mk(0, 0, 1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 32'h200, 1, 1, 0);
        tbl[5] = mk(0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 1, 32'h300, 1, 0, 0);
        tbl[6] = mk(0, 0, 0, 0, 1, 32'h20, 0, 1, 0, 1, 32'h20, 1, 0, 0);
        tbl[7] = mk(1, 32'h44, 0, 0, 0, 0, 0, 1, 0, 1, 32'h44, 1, 1, 0);
        tbl[8] = mk(1, 32'h55, 0, 0, 1, 32'h66, 0, 0, 0, 1, 32'h55, 1, 0 | 1, 0);
        tbl[9] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0, 0, 0);

        // Power-up reset without checks, then the model starts from its reset state.
        v = idle();
        v.rst = 1'b1;
        cur_v = v;
        rst = 1'b1; boot_req = 0; boot_len = 0; boot_valid = 0; imem_busy = 0;
        hazard_stall = 0; halt = 0; trap = 0; trap_vec = 0; ex_br_taken = 0;
        ex_br_addr = 0; id_jmp = 0; id_jmp_addr = 0;
        m_state = 0;
        repeat (2) @(posedge clk);
        #1;
        model_step(v, cur_e);

        // Outputs forced while reset is held, even with trap and boot_valid high.
        v = idle(); v.rst = 1; v.trap = 1; v.trap_vec = 32'hdead; v.boot_valid = 1;
        apply(v);
        chk("rst.pc_boot_en", 32'(pc_boot_en), 32'd1);
        chk("rst.pc_stall", 32'(pc_stall), 32'd1);
        chk("rst.pc_flow_change", 32'(pc_flow_change), 32'd0);
        chk("rst.pc_br_addr", pc_br_addr, 32'd0);
        chk("rst.flush_if", 32'(flush_if), 32'd0);
        chk("rst.flush_id", 32'(flush_id), 32'd0);
        chk("rst.if_valid", 32'(if_valid), 32'd0);
        chk("rst.bmem_we", 32'(bmem_we), 32'd0);
        chk("rst.boot_ready", 32'(boot_ready), 32'd0);
        chk("rst.state", 32'(state), 32'd0);
        next();

        // Three-word boot with gaps between words.
        v = idle(); v.boot_req = 1; v.boot_len = 16'd3;
        apply(v);
        chk("boot.idle_state", 32'(state), 32'd0);
        next();
        for (int i = 0; i < 5; i++) begin
            v = idle(); v.boot_valid = (i % 2 == 0);
            apply(v);
            chk("boot.state", 32'(state), 32'd1);
            chk("boot.pc_boot_en", 32'(pc_boot_en), 32'd1);
            chk("boot.bmem_we", 32'(bmem_we), 32'(i % 2 == 0));
            if (i % 2 == 0) chk("boot.bmem_addr", bmem_addr, 32'(i * 2));
            next();
        end
        v = idle(); v.boot_req = 1; v.boot_len = 16'd5;
        apply(v);
        chk("boot.run_state", 32'(state), 32'd2);
        chk("boot.pc_boot_en_fall", 32'(pc_boot_en), 32'd0);
        chk("boot.ready_off", 32'(boot_ready), 32'd0);
        next();
        v = idle();
        apply(v);
        chk("boot.req_ignored", 32'(state), 32'd2);
        next();

        // Single-cycle arbitration vectors in RUN with nothing pending.
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].in);
            chk($sformatf("tbl%0d.pc_stall", i), 32'(pc_stall), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d.flow", i), 32'(pc_flow_change), 32'(tbl[i].flow));
            if (tbl[i].flow) chk($sformatf("tbl%0d.br_addr", i), pc_br_addr, tbl[i].addr);
            chk($sformatf("tbl%0d.flush_if", i), 32'(flush_if), 32'(tbl[i].fi));
            chk($sformatf("tbl%0d.flush_id", i), 32'(flush_id), 32'(tbl[i].fd));
            chk($sformatf("tbl%0d.if_valid", i), 32'(if_valid), 32'(tbl[i].iv));
            next();
        end

        // Branch during busy stays pending; a later jump is lower rank and dropped.
        v = idle(); v.imem_busy = 1; v.ex_br_taken = 1; v.ex_br_addr = 32'h40;
        apply(v);
        chk("pend.c1_flow", 32'(pc_flow_change), 32'd0);
        chk("pend.c1_flush_id", 32'(flush_id), 32'd1);
        chk("pend.c1_stall", 32'(pc_stall), 32'd1);
        next();
        v = idle(); v.imem_busy = 1; v.id_jmp = 1; v.id_jmp_addr = 32'h80;
        apply(v);
        chk("pend.c2_flush_if", 32'(flush_if), 32'd1);
        chk("pend.c2_flush_id", 32'(flush_id), 32'd0);
        next();
        v = idle(); v.imem_busy = 1;
        apply(v);
        chk("pend.c3_flow", 32'(pc_flow_change), 32'd0);
        next();
        v = idle();
        apply(v);
        chk("pend.issue_flow", 32'(pc_flow_change), 32'd1);
        chk("pend.issue_addr", pc_br_addr, 32'h40);
        chk("pend.issue_if_valid", 32'(if_valid), 32'd0);
        chk("pend.issue_stall", 32'(pc_stall), 32'd0);
        next();
        v = idle();
        apply(v);
        chk("pend.cleared", 32'(pc_flow_change), 32'd0);
        chk("pend.if_valid_back", 32'(if_valid), 32'd1);
        next();

        // Redirect captured in HALT issues on the first non-busy RUN cycle.
        v = idle(); v.halt = 1;
        apply(v);
        next();
        v = idle(); v.halt = 1; v.trap = 1; v.trap_vec = 32'h500;
        apply(v);
        chk("halt.state", 32'(state), 32'd3);
        chk("halt.flow", 32'(pc_flow_change), 32'd0);
        chk("halt.flush_id", 32'(flush_id), 32'd1);
        next();
        v = idle(); v.id_jmp = 1; v.id_jmp_addr = 32'h600;
        apply(v);
        next();
        v = idle(); v.imem_busy = 1;
        apply(v);
        chk("halt.run_busy_state", 32'(state), 32'd2);
        chk("halt.run_busy_flow", 32'(pc_flow_change), 32'd0);
        next();
        v = idle();
        apply(v);
        chk("halt.issue_flow", 32'(pc_flow_change), 32'd1);
        chk("halt.issue_addr", pc_br_addr, 32'h500);
        next();

        // Reset in the middle of a boot load, then a zero-length boot.
        v = idle(); v.rst = 1;
        apply(v);
        next();
        v = idle(); v.boot_req = 1; v.boot_len = 16'd5;
        apply(v);
        next();
        for (int i = 0; i < 2; i++) begin
            v = idle(); v.boot_valid = 1;
            apply(v);
            next();
        end
        v = idle(); v.rst = 1; v.boot_valid = 1;
        apply(v);
        chk("midboot.rst_we", 32'(bmem_we), 32'd0);
        next();
        v = idle(); v.boot_req = 1; v.boot_len = 16'd0;
        apply(v);
        chk("midboot.state_idle", 32'(state), 32'd0);
        chk("midboot.addr_zero", bmem_addr, 32'd0);
        next();
        v = idle();
        apply(v);
        chk("midboot.len0_run", 32'(state), 32'd2);
        next();

        // Performance counters: five stalled RUN cycles and two redirects after reset.
        v = idle(); v.rst = 1;
        apply(v);
        next();
        v = idle(); v.boot_req = 1;
        apply(v);
        next();
        for (int i = 0; i < 5; i++) begin
            v = idle(); v.hazard_stall = 1;
            apply(v);
            next();
        end
        for (int i = 0; i < 2; i++) begin
            v = idle(); v.id_jmp = 1; v.id_jmp_addr = 32'(16 * i + 16);
            apply(v);
            next();
        end
        v = idle();
        apply(v);
`ifdef FETCH_CTRL_PERF_EN
        chk("perf.stall_cnt", perf_stall_cnt, 32'd5);
        chk("perf.redir_cnt", perf_redir_cnt, 32'd2);
`else
        chk("perf.stall_cnt", perf_stall_cnt, 32'd0);
        chk("perf.redir_cnt", perf_redir_cnt, 32'd0);
`endif
        next();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v = idle();
            v.rst          = ($urandom_range(0, 99) == 0);
            v.boot_req     = ($urandom_range(0, 7) == 0);
            v.boot_len     = 16'($urandom_range(0, 4));
            v.boot_valid   = 1'($urandom_range(0, 1));
            v.imem_busy    = ($urandom_range(0, 2) == 0);
            v.hazard_stall = ($urandom_range(0, 3) == 0);
            v.halt         = ($urandom_range(0, 5) == 0);
            v.trap         = ($urandom_range(0, 9) == 0);
            v.trap_vec     = $urandom;
            v.ex_br_taken  = ($urandom_range(0, 5) == 0);
            v.ex_br_addr   = $urandom;
            v.id_jmp       = ($urandom_range(0, 4) == 0);
            v.id_jmp_addr  = $urandom;
            apply(v);
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports (clock and reset first): clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-002 SHALL have: boot_req in 1 start boot load; boot_len in 16 words to load; boot_valid in 1 loader word valid; boot_ready out 1 word accepted.
REQ-003 SHALL have: bmem_we out 1 instruction-memory write strobe; bmem_addr out 32 byte address of boot write.
REQ-004 SHALL have: imem_busy in 1 instruction memory not ready; hazard_stall in 1 decode load-use stall; halt in 1 stop fetch.
REQ-005 SHALL have: trap in 1 trap request; trap_vec in 32 trap target; ex_br_taken in 1 EX branch taken; ex_br_addr in 32; id_jmp in 1 ID jump; id_jmp_addr in 32.
REQ-006 SHALL have: pc_stall out 1; pc_flow_change out 1; pc_br_addr out 32; pc_boot_en out 1 (all drive the PC register).
REQ-007 SHALL have: flush_if out 1; flush_id out 1; if_valid out 1 fetched word valid to decode; state out 2 current FSM state.
REQ-008 SHALL have: perf_stall_cnt out 32; perf_redir_cnt out 32.

Function
REQ-009 FSM states SHALL be IDLE=0, BOOT=1, RUN=2, HALT=3.
REQ-010 IDLE: boot_req -> BOOT, loading word counter=0 and bmem_addr=0; boot_req with boot_len=0 -> RUN directly.
REQ-011 BOOT: boot_ready=1; each cycle boot_valid=1 -> bmem_we=1 (same cycle), counter+1 and bmem_addr+4 next cycle; acceptance of word boot_len-1 -> RUN next cycle.
REQ-012 pc_boot_en SHALL be 1 in IDLE and BOOT, 0 in RUN and HALT; boot_ready and bmem_we SHALL be 0 outside BOOT.
REQ-013 RUN: halt=1 -> HALT; HALT: halt=0 -> RUN; boot_req SHALL be ignored outside IDLE.
REQ-014 Redirect priority SHALL be trap > ex_br_taken > id_jmp; selected target drives pc_br_addr with pc_flow_change=1.
REQ-015 trap or ex_br_taken SHALL assert flush_if and flush_id same cycle; id_jmp alone SHALL assert flush_if only.
REQ-016 pc_stall SHALL = imem_busy | hazard_stall | (state != RUN), except a redirect with imem_busy=0 SHALL force pc_stall=0 (redirect overrides hazard_stall).
REQ-017 Redirect arriving while imem_busy=1 SHALL be latched into a pending register (target + valid); flushes still assert in the arrival cycle.
REQ-018 A later higher-or-equal-priority redirect SHALL overwrite the pending one; a lower-priority one SHALL be dropped.
REQ-019 First cycle imem_busy=0 with pending valid: pc_flow_change=1, pc_br_addr=pending target, pc_stall=0, pending cleared; a new redirect that cycle SHALL win if higher or equal priority.
REQ-020 Redirects in HALT SHALL latch into pending and issue on the first RUN cycle with imem_busy=0.
REQ-021 if_valid SHALL = (state==RUN) & !imem_busy & !flush_if & !pending valid.
REQ-022 pc_flow_change SHALL be 0 when pc_stall=1; outputs SHALL be purely FSM/pending driven with no combinational path from boot_valid to pc_*.

Reset
REQ-023 On rst: state=IDLE, pending cleared, counter=0, bmem_addr=0, perf counters=0.
REQ-024 During rst: pc_boot_en=1, pc_stall=1, pc_flow_change=0, pc_br_addr=0, flush_if=flush_id=0, if_valid=0, boot_ready=0, bmem_we=0.
REQ-025 rst mid-BOOT SHALL abandon the load; a fresh boot_req restarts at address 0.

Configuration
REQ-026 With FETCH_CTRL_PERF_EN defined: perf_stall_cnt SHALL increment each RUN cycle with pc_stall=1; perf_redir_cnt SHALL increment each cycle pc_flow_change=1; both wrap at 2^32.
REQ-027 Without FETCH_CTRL_PERF_EN: perf_stall_cnt and perf_redir_cnt SHALL be constant 0 with no counter registers.

Verification
REQ-028 rst, boot_req with boot_len=3, boot_valid on 3 non-consecutive cycles -> bmem_addr 0,4,8 with bmem_we; RUN one cycle after third word; pc_boot_en falls then.
REQ-029 RUN, same cycle trap (vec 0x100), ex_br_taken (0x200), id_jmp (0x300) -> pc_br_addr=0x100, flush_if=flush_id=1, pc_flow_change=1.
REQ-030 RUN, imem_busy=1 for 3 cycles, ex_br_taken 0x40 in cycle 1, id_jmp 0x80 in cycle 2 -> pending stays 0x40; on imem_busy=0, pc_flow_change=1 with 0x40, if_valid=0 that cycle.
REQ-031 RUN, hazard_stall=1 with id_jmp 0x20 -> pc_stall=0, pc_flow_change=1, flush_if=1, flush_id=0.
REQ-032 rst asserted mid-BOOT after 2 words -> state=IDLE, bmem_addr=0; next boot_req with boot_len=0 -> RUN next cycle.
REQ-033 FETCH_CTRL_PERF_EN defined, 5 stalled RUN cycles and 2 redirects -> perf_stall_cnt=5, perf_redir_cnt=2; undefined -> both 0.
